// File: rtl/cache_stats_pkg.sv
// rtl/cache_stats_pkg.sv - shared widths, defaults and helpers for the cache statistics sampler
package cache_stats_pkg;

  // Cumulative hit counter width presented by the cache
  localparam int HITS_W = 21;

  // Window index carried in each record; wraps modulo 2^16
  localparam int WIN_IDX_W = 16;

  // Dropped-record counter width; saturates rather than wrapping
  localparam int DROP_W = 8;

  // Default number of accesses per sampling window
  localparam int WINDOW_DEFAULT = 1000;

  // Default record buffer depth
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Record layout: {window index, hit delta}
  localparam int REC_WIN_W = WIN_IDX_W;
  localparam int REC_DELTA_W = HITS_W;

  // Saturating increment for the dropped-record counter
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stats_fifo.sv
// rtl/stats_fifo.sv - parameterised synchronous record FIFO with flush and async reset
module stats_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; a push into a full FIFO only lands when a pop frees a slot
  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && !flush && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are never observed while empty, so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cache_stats_sampler.sv
// rtl/cache_stats_sampler.sv - per-window cache hit sampler with buffered records and drop accounting
module cache_stats_sampler #(
  parameter int WINDOW     = cache_stats_pkg::WINDOW_DEFAULT,
  parameter int FIFO_DEPTH = cache_stats_pkg::FIFO_DEPTH_DEFAULT,
  parameter int HITS_W     = cache_stats_pkg::HITS_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                access_valid,
  input  logic [HITS_W-1:0]                   hits,
  input  logic                                clear,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [cache_stats_pkg::WIN_IDX_W-1:0] out_window,
  output logic [HITS_W-1:0]                   out_delta,
  output logic                                overflow,
  output logic [cache_stats_pkg::DROP_W-1:0]  dropped
);

  localparam int WIN_W = cache_stats_pkg::WIN_IDX_W;
  localparam int DRP_W = cache_stats_pkg::DROP_W;
  localparam int ACC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int REC_W = WIN_W + HITS_W;
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(WINDOW - 1);

  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              close_q, close_d;
  logic [HITS_W-1:0] base_q, base_d;
  logic [WIN_W-1:0]  win_idx_q, win_idx_d;
  logic              overflow_q, overflow_d;
  logic [DRP_W-1:0]  dropped_q, dropped_d;

  logic [HITS_W-1:0] delta;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REC_W-1:0]  push_rec, pop_rec;

  // The hits counter lags the access by a clock, so the delta is taken on the cycle after the close
  assign delta    = hits - base_q;
  assign push_rec = {win_idx_q, delta};

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready && !clear;
  assign fifo_push = close_q && !clear;

  assign out_window = out_valid ? pop_rec[REC_W-1 -: WIN_W] : '0;
  assign out_delta  = out_valid ? pop_rec[HITS_W-1:0] : '0;
  assign overflow   = overflow_q;
  assign dropped    = dropped_q;

  // Window counting, delta baseline and drop accounting; clear overrides any access or close
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    close_d    = 1'b0;
    base_d     = base_q;
    win_idx_d  = win_idx_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (clear) begin
      acc_cnt_d  = '0;
      base_d     = hits;
      win_idx_d  = '0;
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else begin
      if (access_valid) begin
        if (acc_cnt_q == ACC_LAST) begin
          acc_cnt_d = '0;
          close_d   = 1'b1;
        end else begin
          acc_cnt_d = acc_cnt_q + 1'b1;
        end
      end
      if (close_q) begin
        base_d    = hits;
        win_idx_d = win_idx_q + 1'b1;
        if (fifo_full && !fifo_pop) begin
          overflow_d = 1'b1;
          dropped_d  = cache_stats_pkg::sat_inc(dropped_q);
        end
      end
    end
  end

  // Sampler state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      close_q    <= 1'b0;
      base_q     <= '0;
      win_idx_q  <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      close_q    <= close_d;
      base_q     <= base_d;
      win_idx_q  <= win_idx_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  stats_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .pop_data  (pop_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_cache_stats_sampler.sv
// tb/tb_cache_stats_sampler.sv - directed self-checking bench for cache_stats_sampler
module tb_cache_stats_sampler;

  logic        clk;
  logic        reset;
  logic        access_valid;
  logic [20:0] hits;
  logic        clear;
  logic        out_ready;

  logic        v4, ov4;
  logic [15:0] w4;
  logic [20:0] d4;
  logic [7:0]  dr4;

  logic        v2, ov2;
  logic [15:0] w2;
  logic [20:0] d2;
  logic [7:0]  dr2;

  int checks = 0;
  int errors = 0;

  int bp_delta [4] = '{4, 12, 20, 28};

  cache_stats_sampler #(.WINDOW(4), .FIFO_DEPTH(4), .HITS_W(21)) u_w4 (
    .clk          (clk),
    .reset        (reset),
    .access_valid (access_valid),
    .hits         (hits),
    .clear        (clear),
    .out_valid    (v4),
    .out_ready    (out_ready),
    .out_window   (w4),
    .out_delta    (d4),
    .overflow     (ov4),
    .dropped      (dr4)
  );

  cache_stats_sampler #(.WINDOW(2), .FIFO_DEPTH(4), .HITS_W(21)) u_w2 (
    .clk          (clk),
    .reset        (reset),
    .access_valid (access_valid),
    .hits         (hits),
    .clear        (clear),
    .out_valid    (v2),
    .out_ready    (out_ready),
    .out_window   (w2),
    .out_delta    (d2),
    .overflow     (ov2),
    .dropped      (dr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    access_valid = 1'b0;
    clear        = 1'b0;
    out_ready    = 1'b0;
    hits         = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    access_valid = 1'b0;
    hits         = '0;
    clear        = 1'b0;
    out_ready    = 1'b0;

    // Reset state
    do_reset();
    check("reset_valid",    32'(v4),  32'd0);
    check("reset_window",   32'(w4),  32'd0);
    check("reset_delta",    32'(d4),  32'd0);
    check("reset_overflow", 32'(ov4), 32'd0);
    check("reset_dropped",  32'(dr4), 32'd0);

    // Basic window: hits seen one cycle after each access rise 0,1,1,2,3,3,3,4
    begin
      int hv [8] = '{0, 1, 1, 2, 3, 3, 3, 4};
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
        access_valid = (k < 8);
        hits = (k == 0) ? 21'd0 : 21'(hv[(k > 8) ? 7 : k - 1]);
        tick();
        if (k == 4 || k == 8) begin
          check("basic_valid",  32'(v4), 32'd1);
          check("basic_window", 32'(w4), (k == 4) ? 32'd0 : 32'd1);
          check("basic_delta",  32'(d4), 32'd2);
        end else begin
          check("basic_idle", 32'(v4), 32'd0);
        end
      end
      access_valid = 1'b0;
    end

    // Hit counter wrap: base 2097150, hits 3 at close
    do_reset();
    clear = 1'b1;
    hits  = 21'd2097150;
    tick();
    clear     = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      access_valid = (j < 4);
      hits = (j < 4) ? 21'd2097150 : 21'd3;
      tick();
    end
    access_valid = 1'b0;
    check("wrap_valid",  32'(v4), 32'd1);
    check("wrap_window", 32'(w4), 32'd0);
    check("wrap_delta",  32'(d4), 32'd5);

    // Backpressure on the WINDOW=2 instance: 6 closes, 4 held, 2 dropped
    do_reset();
    for (int k = 0; k < 13; k++) begin
      access_valid = (k < 12);
      hits = 21'(k * k);
      tick();
    end
    access_valid = 1'b0;
    check("bp_overflow", 32'(ov2), 32'd1);
    check("bp_dropped",  32'(dr2), 32'd2);
    check("bp_valid",    32'(v2),  32'd1);
    check("bp_hold_win", 32'(w2),  32'd0);
    tick();
    check("bp_hold_win2",   32'(w2), 32'd0);
    check("bp_hold_delta",  32'(d2), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid",  32'(v2), 32'd1);
      check("bp_drain_window", 32'(w2), 32'(i));
      check("bp_drain_delta",  32'(d2), 32'(bp_delta[i]));
      tick();
    end
    check("bp_empty_valid", 32'(v2), 32'd0);
    check("bp_empty_delta", 32'(d2), 32'd0);

    // Full with a simultaneous pop: push accepted, no drop
    do_reset();
    for (int k = 0; k < 11; k++) begin
      access_valid = (k < 10);
      out_ready    = (k == 10);
      hits         = 21'(k);
      tick();
    end
    access_valid = 1'b0;
    out_ready    = 1'b0;
    check("fullpop_overflow", 32'(ov2), 32'd0);
    check("fullpop_dropped",  32'(dr2), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fullpop_valid",  32'(v2), 32'd1);
      check("fullpop_window", 32'(w2), 32'(i + 1));
      check("fullpop_delta",  32'(d2), 32'd2);
      tick();
    end
    check("fullpop_empty", 32'(v2), 32'd0);

    // Asynchronous reset mid-operation with two records queued
    do_reset();
    for (int k = 0; k < 11; k++) begin
      access_valid = 1'b1;
      hits = 21'(k);
      tick();
    end
    access_valid = 1'b0;
    check("pre_reset_valid", 32'(v4), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid",  32'(v4), 32'd0);
    check("async_reset_window", 32'(w4), 32'd0);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      access_valid = (j < 4);
      hits = 21'(10 + j);
      tick();
      if (j == 3) check("post_reset_idle", 32'(v4), 32'd0);
    end
    access_valid = 1'b0;
    check("post_reset_valid",  32'(v4), 32'd1);
    check("post_reset_window", 32'(w4), 32'd0);
    check("post_reset_delta",  32'(d4), 32'd14);

    // Clear on the closing access: no record, baseline taken from hits=50
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      access_valid = 1'b1;
      hits  = 21'(47 + k);
      clear = (k == 3);
      tick();
    end
    clear        = 1'b0;
    access_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("clear_no_record", 32'(v4), 32'd0);
    end
    for (int j = 0; j < 5; j++) begin
      access_valid = (j < 4);
      hits = 21'(50 + ((j > 3) ? 3 : j));
      tick();
    end
    access_valid = 1'b0;
    check("clear_valid",  32'(v4), 32'd1);
    check("clear_window", 32'(w4), 32'd0);
    check("clear_delta",  32'(d4), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_stats_sampler.md
CACHE_STATS_SAMPLER -- requirements
Module: cache_stats_sampler

Interface
REQ-001 SHALL have parameter WINDOW, default 1000: accesses per sampling window, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: record buffer depth, power of two, minimum 2.
REQ-003 SHALL have parameter HITS_W, default 21: width of the cumulative hit count from the cache.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high; clears all state.
REQ-006 SHALL have port access_valid  input  1: high for one cycle per address presented to the cache.
REQ-007 SHALL have port hits  input  HITS_W: cumulative hit counter driven by the cache.
REQ-008 SHALL have port clear  input  1: synchronous restart of statistics.
REQ-009 SHALL have port out_valid  output  1: a record is available.
REQ-010 SHALL have port out_ready  input  1: consumer accepts the record.
REQ-011 SHALL have port out_window  output  16: index of the window that produced the record.
REQ-012 SHALL have port out_delta  output  HITS_W: hits within that window.
REQ-013 SHALL have port overflow  output  1: sticky; a record was dropped.
REQ-014 SHALL have port dropped  output  8: count of dropped records, saturating at 255.

Function
REQ-015 SHALL count access_valid cycles in acc_cnt, 0..WINDOW-1; the access at WINDOW-1 closes the window, and acc_cnt returns to 0.
REQ-016 SHALL register a close event one cycle after the closing access (cycle T+1), because the cache's hits value lags by one clock.
REQ-017 At T+1, SHALL compute delta = hits - base modulo 2^HITS_W, then set base <= hits, so a hits wrap yields the correct delta.
REQ-018 SHALL push {win_idx, delta} into the FIFO at the end of T+1; out_valid rises at T+2 if the FIFO was empty (latency 2 cycles from the closing access).
REQ-019 After each close, win_idx SHALL increment modulo 2^16, whether or not the record was stored.
REQ-020 A transfer SHALL occur on a cycle with out_valid and out_ready both high; outputs SHALL hold stable while out_valid is high and out_ready is low.
REQ-021 Push when full without a same-cycle pop SHALL drop the record, set overflow, and increment dropped (saturating at 255).
REQ-022 Push when full with a same-cycle pop SHALL accept the record; occupancy is unchanged.
REQ-023 Push and pop on an empty FIFO SHALL store the record; it is not bypassed, so out_valid rises next cycle.
REQ-024 clear SHALL zero acc_cnt, win_idx, overflow, dropped and the pending close event, flush the FIFO, and set base <= hits; it has priority over a coincident access or close.
REQ-025 out_window and out_delta SHALL read 0 while out_valid is low.

Reset
REQ-026 On reset assertion, independent of clk: acc_cnt=0, win_idx=0, base=0, close event=0, FIFO empty, out_valid=0, out_window=0, out_delta=0, overflow=0, dropped=0.
REQ-027 Reset asserted mid-window or mid-transfer SHALL discard all partial and buffered state; the first window after release counts from access 0.

Structure
REQ-028 Package cache_stats_pkg SHALL hold HITS_W, WIN_IDX_W=16, DROP_W=8, default WINDOW, and the record field widths.
REQ-029 SHALL instantiate one sub-module, stats_fifo: a parameterised synchronous FIFO with push/pop/full/empty and asynchronous reset.
REQ-030 Window counting, delta arithmetic and drop accounting SHALL live in cache_stats_sampler.

Verification
REQ-031 Basic window: WINDOW=4, out_ready=1, 8 back-to-back accesses with hits rising 0,1,1,2,3,3,3,4 -> records {0, delta=2}, then {1, delta=2}; each out_valid appears 2 cycles after the 4th and 8th access.
REQ-032 Counter wrap: HITS_W=21, base=2097150, hits=3 at close -> out_delta=5.
REQ-033 Backpressure: WINDOW=2, FIFO_DEPTH=4, out_ready=0, 12 accesses -> 4 records held, overflow=1, dropped=2; release out_ready -> windows 0,1,2,3 emitted in order, then out_valid=0.
REQ-034 Full with simultaneous pop: FIFO full, out_ready=1 on the push cycle -> no drop, overflow stays 0, occupancy stays 4.
REQ-035 Reset mid-operation: async reset asserted between clock edges after 3 of 4 accesses with 2 records queued -> out_valid=0 immediately; after release, 4 accesses with hits 10->14 -> record {0, delta=14}.
REQ-036 Clear: clear asserted on the closing-access cycle with hits=50 -> no record; next window with hits reaching 53 -> {0, delta=3}.
